ram_arbiter: RTL and testbench

//  Shares the single byte-addressed RAM port (combinational read, byte-enabled posedge write) between two

---
 rtl/ram_arbiter_pkg.sv | 12 +
 rtl/arb_starve_cnt.sv | 29 ++
 rtl/ram_arbiter.sv | 87 ++++++++
 tb/tb_ram_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: grant owner and the "no write" strobe.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_M0   = 2'b01,
        GNT_M1   = 2'b10
    } gnt_e;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the fetch port was denied while requesting.
module arb_starve_cnt #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != LIMIT_C)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign at_limit = (cnt_reg == LIMIT_C);

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for a single RAM port: data port wins, fetch port is
// guaranteed a grant after STARVE_LIMIT consecutive denials.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wenable,
    input  logic [31:0] ram_rdata
);

    gnt_e grant;
    logic m0_at_limit;
    logic m0_denied;

    // Grant is suppressed during reset so no RAM write can slip through.
    always_comb begin
        grant = GNT_NONE;
        if (!rst) begin
            if (m1_req && !(m0_req && m0_at_limit)) begin
                grant = GNT_M1;
            end else if (m0_req) begin
                grant = GNT_M0;
            end
        end
    end

    assign m0_gnt = (grant == GNT_M0);
    assign m1_gnt = (grant == GNT_M1);

    always_comb begin
        ram_addr    = m0_addr;
        ram_wdata   = '0;
        ram_wenable = WSTRB_NONE;
        if (grant == GNT_M1) begin
            ram_addr    = m1_addr;
            ram_wdata   = m1_wdata;
            ram_wenable = m1_wstrb;
        end
    end

    assign m0_denied = m0_req && !m0_gnt;

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (m0_denied),
        .clr      (!m0_denied),
        .at_limit (m0_at_limit)
    );

    // Response data holds its last value between grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt;
            m1_rvalid <= m1_gnt;
            if (m0_gnt) m0_rdata <= ram_rdata;
            if (m1_gnt) m1_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run against a
// behavioural model with its own shadow copy of the RAM contents.
module tb_ram_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0;
    logic [31:0] m0_addr = '0;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0;
    logic [31:0] m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic [3:0]  m1_wstrb = '0;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wenable;
    logic [31:0] ram_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    always #5 clk = ~clk;

    ram_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wenable(ram_wenable),
        .ram_rdata(ram_rdata)
    );

    // Simple RAM: combinational read, byte-enabled posedge write.
    assign ram_rdata = mem[ram_addr[9:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wenable[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        m0_req = 1'b0; m1_req = 1'b0; m1_wstrb = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h40; m1_wdata = 32'hFFFF_FFFF; m1_wstrb = 4'hF;
        @(posedge clk); #1;
        total++; if (m0_gnt !== 1'b0) begin bad++; $display("FAIL reset_m0_gnt got=%b exp=0", m0_gnt); end
        total++; if (m1_gnt !== 1'b0) begin bad++; $display("FAIL reset_m1_gnt got=%b exp=0", m1_gnt); end
        total++; if (ram_wenable !== 4'b0000) begin bad++; $display("FAIL reset_wenable got=%b exp=0000", ram_wenable); end
        total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
        total++; if (m0_rdata !== 32'h0) begin bad++; $display("FAIL reset_m0_rdata got=%h exp=0", m0_rdata); end
        total++; if (m1_rdata !== 32'h0) begin bad++; $display("FAIL reset_m1_rdata got=%h exp=0", m1_rdata); end
        total++; if (mem[16] !== ref_mem[16]) begin bad++; $display("FAIL reset_ram_write got=%h exp=%h", mem[16], ref_mem[16]); end
        @(negedge clk); idle_inputs(); rst = 1'b0;
        @(negedge clk);
        $display("txn reset done");
    endtask

    task automatic test_m0_only();
        m0_req = 1'b1; m0_addr = 32'h10;
        #1;
        total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL m0only_gnt got=%b exp=10", {m0_gnt, m1_gnt}); end
        total++; if (ram_addr !== 32'h10) begin bad++; $display("FAIL m0only_addr got=%h exp=00000010", ram_addr); end
        @(posedge clk); #1;
        total++; if (m0_rvalid !== 1'b1) begin bad++; $display("FAIL m0only_rvalid got=%b exp=1", m0_rvalid); end
        total++; if (m0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL m0only_rdata got=%h exp=deadbeef", m0_rdata); end
        $display("txn m0 fetch addr=00000010 data=%h", m0_rdata);
        @(negedge clk); idle_inputs();
        @(posedge clk); #1;
        total++; if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL m0only_rvalid_drop got=%b exp=0", m0_rvalid); end
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [31:0] old;
        old = ref_mem[8];
        m1_req = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h11223344; m1_wstrb = 4'b0011;
        #1;
        total++; if (m1_gnt !== 1'b1) begin bad++; $display("FAIL st_gnt got=%b exp=1", m1_gnt); end
        total++; if (ram_wenable !== 4'b0011) begin bad++; $display("FAIL st_wenable got=%b exp=0011", ram_wenable); end
        total++; if (ram_wdata !== 32'h11223344) begin bad++; $display("FAIL st_wdata got=%h exp=11223344", ram_wdata); end
        @(posedge clk); #1;
        ref_mem[8] = merge(old, 32'h11223344, 4'b0011);
        total++; if (m1_rvalid !== 1'b1) begin bad++; $display("FAIL st_rvalid got=%b exp=1", m1_rvalid); end
        total++; if (m1_rdata !== old) begin bad++; $display("FAIL st_rdata_prewrite got=%h exp=%h", m1_rdata, old); end
        $display("txn m1 store addr=00000020 wdata=11223344 wstrb=0011");
        @(negedge clk); m1_wstrb = 4'b0000;
        #1;
        total++; if (ram_wenable !== 4'b0000) begin bad++; $display("FAIL ld_wenable got=%b exp=0000", ram_wenable); end
        @(posedge clk); #1;
        total++; if (m1_rdata !== {old[31:16], 16'h3344}) begin bad++; $display("FAIL ld_after_st got=%h exp=%h", m1_rdata, {old[31:16], 16'h3344}); end
        $display("txn m1 load addr=00000020 data=%h", m1_rdata);
        @(negedge clk); idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_starve();
        m0_req = 1'b1; m0_addr = 32'h0; m1_req = 1'b1; m1_addr = 32'h44; m1_wstrb = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            logic [1:0] exp;
            exp = ((c % (LIMIT + 1)) == LIMIT) ? 2'b10 : 2'b01;
            #1;
            total++;
            if ({m0_gnt, m1_gnt} !== exp) begin
                bad++; $display("FAIL starve_cycle%0d got=%b exp=%b", c, {m0_gnt, m1_gnt}, exp);
            end
            $display("txn contended cycle %0d gnt{m0,m1}=%b", c, {m0_gnt, m1_gnt});
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        m1_req = 1'b1; m1_addr = 32'h34; m1_wstrb = 4'b0000;
        @(posedge clk); #1;
        total++; if (m1_rvalid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_rvalid got=%b exp=1", m1_rvalid); end
        @(negedge clk);
        m1_addr = 32'h30; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'hF;
        #1;
        total++; if (m1_gnt !== 1'b1) begin bad++; $display("FAIL rstmid_gnt_before got=%b exp=1", m1_gnt); end
        rst = 1'b1;
        #1;
        total++; if (ram_wenable !== 4'b0000) begin bad++; $display("FAIL rstmid_wenable got=%b exp=0000", ram_wenable); end
        total++; if (m1_gnt !== 1'b0) begin bad++; $display("FAIL rstmid_gnt got=%b exp=0", m1_gnt); end
        total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL rstmid_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
        total++; if (m1_rdata !== 32'h0) begin bad++; $display("FAIL rstmid_rdata got=%h exp=0", m1_rdata); end
        @(posedge clk); #1;
        total++; if (mem[12] !== ref_mem[12]) begin bad++; $display("FAIL rstmid_ram got=%h exp=%h", mem[12], ref_mem[12]); end
        $display("txn reset during m1 store addr=00000030");
        @(negedge clk); idle_inputs(); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle();
        m0_req = 1'b1; m0_addr = 32'h18;
        @(negedge clk); m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h50; m1_wstrb = 4'b0000;
        @(negedge clk); idle_inputs(); m0_addr = 32'h60;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if ({m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL idle_gnt%0d got=%b exp=00", c, {m0_gnt, m1_gnt}); end
            total++; if (ram_wenable !== 4'b0000) begin bad++; $display("FAIL idle_wenable%0d got=%b exp=0000", c, ram_wenable); end
            total++; if (ram_addr !== 32'h60) begin bad++; $display("FAIL idle_addr%0d got=%h exp=00000060", c, ram_addr); end
            @(posedge clk); #1;
            total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL idle_rvalid%0d got=%b exp=00", c, {m0_rvalid, m1_rvalid}); end
            total++; if (m0_rdata !== ref_mem[6]) begin bad++; $display("FAIL idle_m0_hold%0d got=%h exp=%h", c, m0_rdata, ref_mem[6]); end
            total++; if (m1_rdata !== ref_mem[20]) begin bad++; $display("FAIL idle_m1_hold%0d got=%h exp=%h", c, m1_rdata, ref_mem[20]); end
            $display("txn idle cycle %0d", c);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        m0_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m0_addr = 32'(4 * i);
            #1;
            total++; if (m0_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt%0d got=%b exp=1", i, m0_gnt); end
            @(posedge clk); #1;
            total++; if (m0_rvalid !== 1'b1) begin bad++; $display("FAIL b2b_rvalid%0d got=%b exp=1", i, m0_rvalid); end
            total++; if (m0_rdata !== ref_mem[i]) begin bad++; $display("FAIL b2b_rdata%0d got=%h exp=%h", i, m0_rdata, ref_mem[i]); end
            $display("txn m0 fetch addr=%h data=%h", 32'(4 * i), m0_rdata);
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_random();
        int          waited;
        logic [31:0] e0, e1, rd;
        logic        g0, g1;
        logic [7:0]  idx;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        waited = 0; e0 = '0; e1 = '0;
        for (int c = 0; c < 300; c++) begin
            m0_req   = ($urandom_range(0, 9) < 7);
            m1_req   = ($urandom_range(0, 9) < 7);
            m0_addr  = {$urandom, 2'b00} ^ 32'(c % 4);
            m1_addr  = $urandom;
            m1_wdata = $urandom;
            m1_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            // Fetch is denied while the data port asks, unless it has already waited LIMIT cycles.
            g1 = m1_req && !(m0_req && waited >= LIMIT);
            g0 = m0_req && !g1;
            idx = g1 ? m1_addr[9:2] : m0_addr[9:2];
            rd = ref_mem[idx];
            #1;
            total++;
            if ({m0_gnt, m1_gnt} !== {g0, g1}) begin
                bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, {m0_gnt, m1_gnt}, {g0, g1});
            end
            total++;
            if (ram_wenable !== (g1 ? m1_wstrb : 4'b0000)) begin
                bad++; $display("FAIL rnd_wenable c=%0d got=%b exp=%b", c, ram_wenable, g1 ? m1_wstrb : 4'b0000);
            end
            total++;
            if (ram_addr !== (g1 ? m1_addr : m0_addr)) begin
                bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, ram_addr, g1 ? m1_addr : m0_addr);
            end
            @(posedge clk); #1;
            if (g1) ref_mem[idx] = merge(rd, m1_wdata, m1_wstrb);
            if (g0) e0 = rd;
            if (g1) e1 = rd;
            waited = (m0_req && !g0) ? waited + 1 : 0;
            total++;
            if ({m0_rvalid, m1_rvalid} !== {g0, g1}) begin
                bad++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, {m0_rvalid, m1_rvalid}, {g0, g1});
            end
            total++;
            if (m0_rdata !== e0 || m1_rdata !== e1) begin
                bad++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h/%h", c, m0_rdata, m1_rdata, e0, e1);
            end
            if (g0 || g1)
                $display("txn rnd c=%0d %s addr=%h wstrb=%b rdata=%h", c, g0 ? "m0" : "m1",
                         g1 ? m1_addr : m0_addr, g1 ? m1_wstrb : 4'b0000, rd);
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
        total++;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                bad++; $display("FAIL rnd_ram_final idx=%0d got=%h exp=%h", i, mem[i], ref_mem[i]);
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4]     = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        @(negedge clk);
        test_reset();
        test_m0_only();
        test_store_load();
        test_starve();
        test_reset_mid();
        test_idle();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
